// File: rtl/psu_pkg.sv
// Shared definitions for the PSU rail front-end: sampler FSM states and ADC frame layout.
package psu_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } sampler_state_e;

    // A frame is trusted only when the ADC's leading bits came back as zeros.
    function automatic logic lead_zeros_ok(input logic [FRAME_BITS-1:0] frame);
        return frame[FRAME_BITS-1 -: LEAD_ZEROS] == '0;
    endfunction

endpackage

// File: rtl/moving_avg.sv
// Power-of-two moving average over the last AVG_LENGTH accepted samples.
module moving_avg
    import psu_pkg::*;
#(
    parameter int AVG_LENGTH = 4,
    parameter int AVG_DIV    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic [DATA_BITS-1:0] avg,
    output logic                 avg_valid
);

    localparam int SUM_W  = DATA_BITS + AVG_DIV;
    localparam int PTR_W  = (AVG_DIV > 0) ? AVG_DIV : 1;
    localparam int FILL_W = $clog2(AVG_LENGTH + 1);

    logic [DATA_BITS-1:0] avg_buf [AVG_LENGTH];
    logic [SUM_W-1:0]     sum_p0;
    logic [SUM_W-1:0]     sum_next;
    logic [PTR_W-1:0]     wr_ptr;
    logic [FILL_W-1:0]    fill;
    logic                 full_next;

    function automatic logic [DATA_BITS-1:0] trunc_avg(input logic [SUM_W-1:0] s);
        return DATA_BITS'(s >> AVG_DIV);
    endfunction

    // Modular subtract-then-add: the final sum always fits SUM_W bits.
    always_comb begin
        sum_next  = sum_p0 - SUM_W'(avg_buf[wr_ptr]) + SUM_W'(in_data);
        full_next = (fill >= FILL_W'(AVG_LENGTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_LENGTH; i++) begin
                avg_buf[i] <= '0;
            end
            sum_p0    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (in_valid) begin
                avg_buf[wr_ptr] <= in_data;
                sum_p0          <= sum_next;
                wr_ptr          <= (wr_ptr == PTR_W'(AVG_LENGTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (fill != FILL_W'(AVG_LENGTH)) begin
                    fill <= fill + 1'b1;
                end
                if (full_next) begin
                    avg       <= trunc_avg(sum_next);
                    avg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// Serial ADC front-end for one PSU rail: frames cs/sck, captures din, checks and averages samples.
module adc_spi_sampler
    import psu_pkg::*;
#(
    parameter int SPI_CLK_DIVIDER = 11,
    parameter int AVG_LENGTH      = 4,
    parameter int AVG_DIV         = 2,
    parameter int WAIT_TIME       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 din,
    output logic                 cs,
    output logic                 sck,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic [DATA_BITS-1:0] avg,
    output logic                 avg_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV_W  = $clog2(SPI_CLK_DIVIDER);
    localparam int WAIT_W = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
    localparam int RISE_W = $clog2(FRAME_BITS + 1);

    sampler_state_e          state;
    sampler_state_e          state_next;
    logic [DIV_W-1:0]        div_cnt;
    logic [RISE_W-1:0]       rise_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [FRAME_BITS-1:0]   shift_p0;
    logic                    frame_done;
    logic                    sck_wrap;
    logic                    sck_rise;

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = CONV;
            end
            // One extra CONV cycle after the last rise lets the final bit land in shift_p0.
            CONV: begin
                if (rise_cnt == RISE_W'(FRAME_BITS)) begin
                    state_next = QUIET;
                    frame_done = 1'b1;
                end
            end
            QUIET: begin
                if (wait_cnt == WAIT_W'(WAIT_TIME - 1)) state_next = en ? CONV : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sck_wrap = (state == CONV) && (div_cnt == DIV_W'(SPI_CLK_DIVIDER - 1))
                      && (rise_cnt != RISE_W'(FRAME_BITS));
    assign sck_rise = sck_wrap && !sck;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cs           <= 1'b1;
            sck          <= 1'b1;
            div_cnt      <= '0;
            rise_cnt     <= '0;
            wait_cnt     <= '0;
            shift_p0     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cs           <= (state_next != CONV);
            busy         <= (state_next != IDLE);
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (state != CONV) begin
                div_cnt  <= '0;
                rise_cnt <= '0;
                sck      <= 1'b1;
            end else begin
                div_cnt <= sck_wrap ? '0 : div_cnt + 1'b1;
                if (sck_wrap) sck <= ~sck;
                if (sck_rise) begin
                    shift_p0 <= {shift_p0[FRAME_BITS-2:0], din};
                    rise_cnt <= rise_cnt + 1'b1;
                end
            end

            wait_cnt <= (state == QUIET && state_next == QUIET) ? wait_cnt + 1'b1 : '0;

            if (frame_done) begin
                if (lead_zeros_ok(shift_p0)) begin
                    sample       <= shift_p0[DATA_BITS-1:0];
                    sample_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    moving_avg #(
        .AVG_LENGTH(AVG_LENGTH),
        .AVG_DIV   (AVG_DIV)
    ) u_avg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (sample_valid),
        .in_data  (sample),
        .avg      (avg),
        .avg_valid(avg_valid)
    );

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboarded bench for adc_spi_sampler with a behavioural serial ADC model.
module tb_adc_spi_sampler;

    localparam int DIV       = 2;
    localparam int WAIT      = 3;
    localparam int ALEN      = 4;
    localparam int ADIV      = 2;
    localparam int FRAME_CYC = 32 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        din = 1'b0;
    logic        cs, sck, sample_valid, avg_valid, frame_err, busy;
    logic [11:0] sample, avg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] adc_q[$];
    int sample_q[$];
    int avg_q[$];
    int err_q[$];
    int model_buf[$];
    int last_good = 0;

    int cyc = 0;
    int rise_cnt = 0, fall_cnt = 0, sv_cnt = 0, err_cnt = 0, avg_cnt = 0;
    int last_rise = 0, last_sv = 0, last_csfall = 0;
    int csf_q[$];

    adc_spi_sampler #(
        .SPI_CLK_DIVIDER(DIV),
        .AVG_LENGTH     (ALEN),
        .AVG_DIV        (ADIV),
        .WAIT_TIME      (WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .cs          (cs),
        .sck         (sck),
        .sample      (sample),
        .sample_valid(sample_valid),
        .avg         (avg),
        .avg_valid   (avg_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue a frame for the ADC and record what the sampler should publish for it.
    task automatic push_frame(input logic [15:0] f);
        int s;
        adc_q.push_back(f);
        if (f[15:12] == 4'h0) begin
            sample_q.push_back(int'(f[11:0]));
            model_buf.push_back(int'(f[11:0]));
            if (model_buf.size() > ALEN) void'(model_buf.pop_front());
            if (model_buf.size() == ALEN) begin
                s = 0;
                foreach (model_buf[i]) s += model_buf[i];
                avg_q.push_back(s / ALEN);
            end
            last_good = int'(f[11:0]);
        end else begin
            err_q.push_back(last_good);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag, input int target, input int bound);
        int t = 0;
        while ((sv_cnt + err_cnt) < target && t < bound) begin
            tick();
            t++;
        end
        check_val(tag, sv_cnt + err_cnt, target);
    endtask

    task automatic wait_falls(input string tag, input int target, input int bound);
        int t = 0;
        while (fall_cnt < target && t < bound) begin
            tick();
            t++;
        end
        check_val(tag, fall_cnt, target);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int t = 0;
        while (busy && t < bound) begin
            tick();
            t++;
        end
        check_val(tag, int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick(2);
        adc_q.delete();
        sample_q.delete();
        avg_q.delete();
        err_q.delete();
        model_buf.delete();
        last_good = 0;
        rst = 1'b0;
        tick();
    endtask

    // ADC model: MSB driven on the first sck fall, one bit per fall thereafter.
    initial begin
        logic [15:0] fr;
        int idx;
        forever begin
            @(negedge cs);
            fr  = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
            idx = 0;
            while (cs == 1'b0 && idx < 16) begin
                @(negedge sck or posedge cs);
                if (cs == 1'b0) begin
                    din = fr[15-idx];
                    idx++;
                end
            end
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin
        logic cs_prev, sck_prev;
        cs_prev  = 1'b1;
        sck_prev = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (cs_prev && !cs) begin
                last_csfall = cyc;
                csf_q.push_back(cyc);
            end
            if (!sck_prev && sck) begin
                rise_cnt++;
                last_rise = cyc;
            end
            if (sck_prev && !sck) fall_cnt++;
            if (sample_valid) begin
                sv_cnt++;
                last_sv = cyc;
                if (sample_q.size() == 0) check_val("sample_valid_unexpected", int'(sample_valid), 0);
                else check_val("sample", int'(sample), sample_q.pop_front());
            end
            if (frame_err) begin
                err_cnt++;
                if (err_q.size() == 0) check_val("frame_err_unexpected", int'(frame_err), 0);
                else check_val("sample_held", int'(sample), err_q.pop_front());
            end
            if (avg_valid) begin
                avg_cnt++;
                check_val("avg_lag", cyc - last_sv, 1);
                if (avg_q.size() == 0) check_val("avg_valid_unexpected", int'(avg_valid), 0);
                else check_val("avg", int'(avg), avg_q.pop_front());
            end
            cs_prev  = cs;
            sck_prev = sck;
        end
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: got cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base_r, base_f, base_sv, base_err, base_avg, base_csf;

        // Reset state
        tick(3);
        check_val("rst_cs", int'(cs), 1);
        check_val("rst_sck", int'(sck), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_sample", int'(sample), 0);
        check_val("rst_avg", int'(avg), 0);
        check_val("rst_strobes", int'({sample_valid, avg_valid, frame_err}), 0);
        rst = 1'b0;
        tick();

        // Single frame with a one-cycle enable pulse
        push_frame(16'h0ABC);
        base_r  = rise_cnt;
        base_sv = sv_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_idle("t1_idle_timeout", 300);
        check_val("t1_csfall_to_rise16", last_rise - last_csfall, FRAME_CYC);
        check_val("t1_rises", rise_cnt - base_r, 16);
        check_val("t1_sv_lag", last_sv - last_rise, 1);
        check_val("t1_sv_count", sv_cnt - base_sv, 1);
        check_val("t1_busy_span", cyc - last_csfall, FRAME_CYC + 1 + WAIT);
        check_val("t1_sample_reg", int'(sample), 12'hABC);
        check_val("t1_cs_idle", int'(cs), 1);

        // Averaging with en held high
        do_reset();
        for (int v = 100; v <= 500; v += 100) push_frame(16'(v));
        base_csf = csf_q.size();
        base_avg = avg_cnt;
        base_sv  = sv_cnt + err_cnt;
        en = 1'b1;
        wait_done("t2_done_timeout", base_sv + 5, 600);
        en = 1'b0;
        wait_idle("t2_idle_timeout", 50);
        tick(2);
        check_val("t2_avg_count", avg_cnt - base_avg, 2);
        check_val("t2_avg_final", int'(avg), 350);
        check_val("t2_frames", csf_q.size() - base_csf, 5);
        check_val("t2_period_a", csf_q[base_csf+1] - csf_q[base_csf], FRAME_CYC + 1 + WAIT);
        check_val("t2_period_b", csf_q[base_csf+4] - csf_q[base_csf+3], FRAME_CYC + 1 + WAIT);

        // Bad frame in the middle of a run
        do_reset();
        push_frame(16'd100);
        push_frame(16'd200);
        push_frame(16'hF123);
        push_frame(16'd300);
        push_frame(16'd400);
        push_frame(16'd500);
        base_avg = avg_cnt;
        base_err = err_cnt;
        base_sv  = sv_cnt + err_cnt;
        en = 1'b1;
        wait_done("t3_done_timeout", base_sv + 6, 700);
        en = 1'b0;
        wait_idle("t3_idle_timeout", 50);
        tick(2);
        check_val("t3_err_count", err_cnt - base_err, 1);
        check_val("t3_avg_count", avg_cnt - base_avg, 2);
        check_val("t3_avg_final", int'(avg), 350);

        // Full scale and truncation
        do_reset();
        repeat (4) push_frame(16'h0FFF);
        push_frame(16'h0001);
        base_avg = avg_cnt;
        base_sv  = sv_cnt + err_cnt;
        en = 1'b1;
        wait_done("t4_done_timeout", base_sv + 5, 600);
        en = 1'b0;
        wait_idle("t4_idle_timeout", 50);
        tick(2);
        check_val("t4_avg_count", avg_cnt - base_avg, 2);
        check_val("t4_avg_final", int'(avg), 3071);

        // en dropped mid-frame
        do_reset();
        push_frame(16'h0123);
        base_f  = fall_cnt;
        base_sv = sv_cnt;
        en = 1'b1;
        wait_falls("t5_fall5_timeout", base_f + 5, 200);
        en = 1'b0;
        wait_done("t5_done_timeout", sv_cnt + err_cnt + 1, 200);
        wait_idle("t5_idle_timeout", 50);
        check_val("t5_sv_count", sv_cnt - base_sv, 1);
        check_val("t5_cs", int'(cs), 1);
        check_val("t5_sck", int'(sck), 1);
        base_f   = fall_cnt;
        base_csf = csf_q.size();
        tick(40);
        check_val("t5_no_sck", fall_cnt - base_f, 0);
        check_val("t5_no_cs", csf_q.size() - base_csf, 0);

        // Reset mid-frame
        do_reset();
        adc_q.push_back(16'h0555);
        base_f = fall_cnt;
        en = 1'b1;
        wait_falls("t6_fall8_timeout", base_f + 8, 200);
        rst = 1'b1;
        tick();
        check_val("t6_cs", int'(cs), 1);
        check_val("t6_sck", int'(sck), 1);
        check_val("t6_busy", int'(busy), 0);
        check_val("t6_strobes", int'({sample_valid, avg_valid, frame_err}), 0);
        do_reset();
        push_frame(16'd10);
        push_frame(16'd20);
        push_frame(16'd30);
        push_frame(16'd40);
        base_avg = avg_cnt;
        base_sv  = sv_cnt + err_cnt;
        en = 1'b1;
        wait_done("t6_done_timeout", base_sv + 4, 500);
        en = 1'b0;
        wait_idle("t6_idle_timeout", 50);
        tick(2);
        check_val("t6_avg_count", avg_cnt - base_avg, 1);
        check_val("t6_avg_final", int'(avg), 25);

        check_val("sb_sample_left", sample_q.size(), 0);
        check_val("sb_avg_left", avg_q.size(), 0);
        check_val("sb_err_left", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
